// File: rtl/mem_pkg.sv
// Shared definitions for the memory access unit: access type codes, size lookup,
// issue-type mapping and FSM state encoding.
package mem_pkg;

  localparam int DM_BYTES_DEFAULT = 32;

  localparam logic [2:0] DM_W  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_HU = 3'b010;
  localparam logic [2:0] DM_B  = 3'b011;
  localparam logic [2:0] DM_BU = 3'b100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  function automatic logic [2:0] dm_size(input logic [2:0] t);
    case (t)
      DM_W:        dm_size = 3'd4;
      DM_H, DM_HU: dm_size = 3'd2;
      default:     dm_size = 3'd1;
    endcase
  endfunction

  // The memory only knows signed-agnostic widths; extension happens on the way back.
  function automatic logic [2:0] dm_issue_type(input logic [2:0] t);
    case (t)
      DM_H, DM_HU: dm_issue_type = DM_H;
      DM_B, DM_BU: dm_issue_type = DM_B;
      default:     dm_issue_type = DM_W;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational sign/zero extension of raw little-endian load data by access type.
module load_extend
  import mem_pkg::*;
(
  input  logic [2:0]  ld_type,
  input  logic [31:0] raw,
  output logic [31:0] extended
);

  always_comb begin
    extended = raw;
    case (ld_type)
      DM_H:    extended = {{16{raw[15]}}, raw[15:0]};
      DM_HU:   extended = {16'd0, raw[15:0]};
      DM_B:    extended = {{24{raw[7]}}, raw[7:0]};
      DM_BU:   extended = {24'd0, raw[7:0]};
      default: extended = raw;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage controller: handshakes a load/store, range-checks it, drives registered
// memory signals and returns an extended load response. Option: MISALIGN_TRAP_EN.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DM_BYTES = DM_BYTES_DEFAULT,
  parameter int DM_AW    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [2:0]       req_type,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_rdata,
  output logic             resp_err,
  output logic             dm_write,
  output logic [DM_AW-1:0] dm_address,
  output logic [31:0]      dm_dataIn,
  output logic [2:0]       dm_type,
  input  logic [31:0]      dm_dataOut
);

  state_e      state, state_nxt;
  logic        accept;
  logic [32:0] last_byte;
  logic        type_err, range_err, align_err, req_err;
  logic [2:0]  type_p1;
  logic        wr_p1, err_p1;
  logic [31:0] ext_data;

  // 33-bit sum so an address near 2^32 cannot wrap back into range
  assign last_byte = {1'b0, req_addr} + {30'd0, dm_size(req_type)} - 33'd1;
  assign range_err = last_byte >= 33'(DM_BYTES);
  assign type_err  = req_type > DM_BU;

`ifdef MISALIGN_TRAP_EN
  assign align_err = ((req_type == DM_H || req_type == DM_HU) && req_addr[0]) ||
                     (req_type == DM_W && req_addr[1:0] != 2'b00);
`else
  assign align_err = 1'b0;
`endif

  assign req_err   = type_err || range_err || align_err;
  assign req_ready = (state == IDLE) || (state == RESP && resp_ready);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = accept ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  load_extend u_load_extend (
    .ld_type  (type_p1),
    .raw      (dm_dataOut),
    .extended (ext_data)
  );

  // p1: request captured at accept, memory driven during ISSUE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      dm_write   <= 1'b0;
      dm_address <= '0;
      dm_dataIn  <= '0;
      dm_type    <= DM_W;
      type_p1    <= DM_W;
      wr_p1      <= 1'b0;
      err_p1     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        dm_write   <= req_write && !req_err;
        dm_address <= req_addr[DM_AW-1:0];
        dm_dataIn  <= req_wdata;
        dm_type    <= dm_issue_type(req_type);
        type_p1    <= req_type;
        wr_p1      <= req_write;
        err_p1     <= req_err;
      end else begin
        dm_write   <= 1'b0;
      end
    end
  end

  // p2: read data sampled at the end of ISSUE, held until consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else if (state == ISSUE) begin
      resp_valid <= 1'b1;
      resp_err   <= err_p1;
      resp_rdata <= (err_p1 || wr_p1) ? 32'd0 : ext_data;
    end else if (state == RESP && resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed, table-driven bench for mem_access_unit with a byte-array memory model.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk, rst;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_type;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        dm_write;
  logic [5:0]  dm_address;
  logic [31:0] dm_dataIn, dm_dataOut;
  logic [2:0]  dm_type;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  logic init_done;
  logic [7:0] mem [0:31];

  mem_access_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .dm_write(dm_write), .dm_address(dm_address), .dm_dataIn(dm_dataIn),
    .dm_type(dm_type), .dm_dataOut(dm_dataOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Little-endian byte memory; bytes past the end read as zero and ignore writes
  always_comb begin
    dm_dataOut = 32'd0;
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = int'(dm_address) + k;
      if (idx < 32) dm_dataOut[8*k +: 8] = mem[idx];
    end
  end

  always @(posedge clk) begin
    if (!init_done) begin
      for (int k = 0; k < 32; k++) mem[k] <= 8'h00;
    end else if (dm_write) begin
      for (int k = 0; k < 4; k++) begin
        int idx;
        idx = int'(dm_address) + k;
        if (idx < 32 && (dm_type == DM_W || (dm_type == DM_H && k < 2) || (dm_type == DM_B && k < 1)))
          mem[idx] <= dm_dataIn[8*k +: 8];
      end
    end
  end

  always @(posedge clk) if (dm_write) wr_cnt <= wr_cnt + 1;

  typedef struct {
    logic        wr;
    logic [2:0]  t;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [0:20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=handshake", nm);
  endtask

  task automatic do_req(input logic w, input logic [2:0] t, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic e, output int wdelta);
    int n;
    int c0;
    c0 = wr_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_type = t; req_addr = a; req_wdata = d;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) timeout("req_ready");
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) timeout("resp_valid");
    rd = resp_rdata;
    e  = resp_err;
    @(negedge clk);
    wdelta = wr_cnt - c0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    int          wd;
    int          n;

    init_done = 1'b0;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_type = 3'b000;
    req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b1;

    vecs[0]  = '{1'b1, DM_W,   32'd4,          32'h8badf00d, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b0, DM_W,   32'd4,          32'h0,        32'h8badf00d, 1'b0};
    vecs[2]  = '{1'b0, DM_B,   32'd4,          32'h0,        32'h0000000d, 1'b0};
    vecs[3]  = '{1'b0, DM_B,   32'd7,          32'h0,        32'hffffff8b, 1'b0};
    vecs[4]  = '{1'b0, DM_BU,  32'd7,          32'h0,        32'h0000008b, 1'b0};
    vecs[5]  = '{1'b0, DM_H,   32'd6,          32'h0,        32'hffff8bad, 1'b0};
    vecs[6]  = '{1'b0, DM_HU,  32'd6,          32'h0,        32'h00008bad, 1'b0};
    vecs[7]  = '{1'b1, DM_W,   32'd29,         32'h11223344, 32'h00000000, 1'b1};
    vecs[8]  = '{1'b0, DM_H,   32'd31,         32'h0,        32'h00000000, 1'b1};
    vecs[9]  = '{1'b0, 3'b101, 32'd0,          32'h0,        32'h00000000, 1'b1};
    vecs[10] = '{1'b1, 3'b111, 32'd0,          32'hffffffff, 32'h00000000, 1'b1};
    vecs[11] = '{1'b0, DM_B,   32'd31,         32'h0,        32'h00000000, 1'b0};
    vecs[12] = '{1'b1, DM_B,   32'd31,         32'h123456a5, 32'h00000000, 1'b0};
    vecs[13] = '{1'b0, DM_B,   32'd31,         32'h0,        32'hffffffa5, 1'b0};
    vecs[14] = '{1'b0, DM_BU,  32'd31,         32'h0,        32'h000000a5, 1'b0};
    vecs[15] = '{1'b0, DM_HU,  32'd30,         32'h0,        32'h0000a500, 1'b0};
    vecs[16] = '{1'b0, DM_W,   32'd28,         32'h0,        32'ha5000000, 1'b0};
    vecs[17] = '{1'b0, DM_B,   32'hffffffff,   32'h0,        32'h00000000, 1'b1};
    vecs[18] = '{1'b1, DM_H,   32'd0,          32'hdead1234, 32'h00000000, 1'b0};
    vecs[19] = '{1'b0, DM_W,   32'd0,          32'h0,        32'h00001234, 1'b0};
    vecs[20] = '{1'b0, DM_W,   32'd32,         32'h0,        32'h00000000, 1'b1};

    repeat (3) @(negedge clk);
    init_done = 1'b1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_dm_write", {31'd0, dm_write}, 32'd0);
    chk("rst_dm_address", {26'd0, dm_address}, 32'd0);
    chk("rst_dm_dataIn", dm_dataIn, 32'd0);
    chk("rst_dm_type", {29'd0, dm_type}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 21; i++) begin
      do_req(vecs[i].wr, vecs[i].t, vecs[i].a, vecs[i].d, rd, e, wd);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
      chk($sformatf("vec%0d_writes", i), wd, (vecs[i].wr && !vecs[i].exp_err) ? 32'd1 : 32'd0);
    end
    chk("mem_29_31", {8'd0, mem[29], mem[30], mem[31]}, 32'h000000a5);

    // Misaligned halfword store at 5
    do_req(1'b1, DM_H, 32'd5, 32'h0000beef, rd, e, wd);
`ifdef MISALIGN_TRAP_EN
    chk("mis_err", {31'd0, e}, 32'd1);
    chk("mis_writes", wd, 32'd0);
    chk("mis_mem", {16'd0, mem[6], mem[5]}, 32'h0000adf0);
`else
    chk("mis_err", {31'd0, e}, 32'd0);
    chk("mis_writes", wd, 32'd1);
    chk("mis_mem", {16'd0, mem[6], mem[5]}, 32'h0000beef);
`endif

    // Response stall with a second request waiting
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_type = DM_B; req_addr = 32'd4; req_wdata = 32'd0;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) timeout("stall_req_ready");
    @(negedge clk);
    req_type = DM_BU; req_addr = 32'd7;
    chk("lat_issue_resp_valid", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    chk("lat_resp_valid", {31'd0, resp_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_req_ready", i), {31'd0, req_ready}, 32'd0);
      chk($sformatf("stall%0d_resp_valid", i), {31'd0, resp_valid}, 32'd1);
      chk($sformatf("stall%0d_rdata", i), resp_rdata, 32'h0000000d);
    end
    resp_ready = 1'b1;
    #1;
    chk("release_req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_issue_resp_valid", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    chk("b2b_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("b2b_rdata", resp_rdata, 32'h0000008b);
    @(negedge clk);
    chk("b2b_idle", {31'd0, resp_valid}, 32'd0);

    // Asynchronous reset during ISSUE of a store
    req_valid = 1'b1; req_write = 1'b1; req_type = DM_W; req_addr = 32'd8; req_wdata = 32'hcafebabe;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("rst_issue_dm_write", {31'd0, dm_write}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_dm_write", {31'd0, dm_write}, 32'd0);
    chk("rst_async_resp_valid", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_no_resp", {31'd0, resp_valid}, 32'd0);
    chk("rst_idle_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mem_8", {mem[11], mem[10], mem[9], mem[8]}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
